line_drive_ctrl: RTL and testbench
==================================

Name: line_drive_ctrl

Overview:
- Decision stage that sits directly upstream of the motor driver and produces the driver's `mode[1:0]` and `speed[9:0]` inputs.
- Consumes three IR line-tracker bits and an obstacle flag from the ultrasonic front end.
- Filters the sensors and runs a tracking FSM: follow, turn, search, halt.
- Ramps speed up gradually so the car does not jerk or stall at start and on direction changes.

Parameters:
- FILT_CYC, 16: consecutive stable cycles required before a raw sensor pattern is accepted.
- RAMP_DIV, 1000: clock cycles per ramp tick.
- RAMP_STEP, 50: speed increment per ramp tick.
- FWD_SPEED, 700: target speed in FWD.
- TURN_SPEED, 550: target speed in LEFT/RIGHT.
- SEARCH_SPEED, 450: target speed in LOST.
- LOST_CYC, 50000000: cycles allowed in LOST before HALT.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- enable, input, 1: run request; low forces IDLE.
- sensor, input, 3: {left, centre, right}; 1 = line detected.
- obstacle, input, 1: 1 = object too close.
- mode, output, 2: 00 stop, 01 forward, 10 turn left, 11 turn right.
- speed, output, 10: PWM duty to the motor driver, 0..1023.
- state_dbg, output, 3: current FSM state encoding, for LEDs.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and is the only reset.
- All outputs are registered.
- Reset values: mode=00, speed=0, state=IDLE, filtered sensor=010, candidate=010, filter count=0, last_dir=LEFT, ramp divider=0, lost counter=0.
- Sensor filter:
  - If raw != candidate: candidate<=raw, count<=0.
  - Else if count==FILT_CYC-1: filtered<=candidate.
  - Else count++.
  - A pattern held stable from cycle t is visible on filtered at t+FILT_CYC+1. Glitches shorter than that are ignored.
- FSM states: IDLE, FWD, LEFT, RIGHT, LOST, BLOCK, HALT.
- Transition priority, evaluated every cycle: rst > !enable > obstacle > lost timeout > filtered sensor.
  - !enable in any state: next state IDLE.
  - IDLE with enable=1: enter the sensor-mapped state next cycle.
  - obstacle=1 in FWD/LEFT/RIGHT/LOST: next state BLOCK.
  - BLOCK with obstacle=0: enter the sensor-mapped state.
  - Sensor map from FWD/LEFT/RIGHT/LOST/IDLE/BLOCK:
    - 010, 111 -> FWD
    - 110, 100 -> LEFT
    - 011, 001 -> RIGHT
    - 000 -> LOST
    - 101 -> stay in current state (from IDLE/BLOCK, 101 -> FWD).
  - LOST counter: cleared on LOST entry, increments each cycle in LOST. At LOST_CYC-1 the next state is HALT.
  - HALT: left only via enable=0 (to IDLE). Sensor and obstacle are ignored.
- last_dir: updated to LEFT/RIGHT whenever LEFT/RIGHT is entered.
- Mode decode from the registered state:
  - IDLE/BLOCK/HALT -> 00
  - FWD -> 01
  - LEFT -> 10
  - RIGHT -> 11
  - LOST -> 10 if last_dir=LEFT, else 11 (spin toward the last seen side).
  - mode changes one cycle after the state register changes.
- Target speed: FWD_SPEED, TURN_SPEED or SEARCH_SPEED by state; 0 in IDLE/BLOCK/HALT.
- Ramp divider: free-running 0..RAMP_DIV-1; a tick occurs when it wraps.
- Speed update:
  - If target < speed: speed<=target next cycle (snap down, no ramp).
  - Else on a tick: speed<=min(speed+RAMP_STEP, target). Compute in 11 bits so the sum cannot wrap past 1023.
  - Else hold.
- Entering BLOCK or IDLE forces speed to 0 within one cycle. Resuming ramps up from 0.
- Simultaneous events: an obstacle and a sensor change in the same cycle -> BLOCK. enable falling in the same cycle as a LOST timeout -> IDLE.
- rst asserted mid-ramp or mid-LOST: all state returns to reset values on the next edge.

Test Plan (bench overrides: FILT_CYC=4, RAMP_DIV=4, RAMP_STEP=100, FWD_SPEED=700, TURN_SPEED=550, SEARCH_SPEED=450, LOST_CYC=64):
1. Reset then enable=1, sensor=010 -> state FWD, mode=01. Speed climbs 0,100,...,600,700, one step every 4 cycles, then holds at 700.
2. In FWD at 700, sensor=110 held 10 cycles -> filtered updates 5 cycles after the change. Then mode=10 and speed snaps to 550 one cycle after the state change. A 2-cycle 110 glitch causes no change.
3. sensor=000 from LEFT -> LOST, mode=10 (last_dir LEFT), speed=450. After 64 cycles in LOST -> HALT, mode=00, speed=0. sensor=010 then keeps HALT. enable=0 -> IDLE.
4. In FWD at 700, pulse obstacle=1 -> BLOCK, mode=00, speed=0 next cycle. obstacle=0 with sensor=010 -> FWD, ramp restarts from 0.
5. Assert rst during a ramp at speed=300 -> next edge mode=00, speed=0, state_dbg=IDLE. enable=0 at any time -> IDLE within one cycle.
6. sensor=101 while in RIGHT -> stays RIGHT, mode=11. sensor=111 -> FWD.

Source files
------------

// File: rtl/line_drive_ctrl.sv
// line_drive_ctrl
//   Decision stage in front of the motor driver. Debounces the three IR
//   line-tracker bits, runs the tracking FSM (follow / turn / search / halt,
//   plus obstacle block) and ramps the PWM duty so the car never jerks.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   enable     run request, low forces IDLE
//   sensor     {left, centre, right}, 1 = line detected
//   obstacle   1 = object too close (ultrasonic front end)
//   mode       00 stop, 01 forward, 10 turn left, 11 turn right (registered)
//   speed      PWM duty 0..1023 (registered)
//   state_dbg  current FSM state encoding for LEDs
module line_drive_ctrl #(
  parameter int FILT_CYC     = 16,
  parameter int RAMP_DIV     = 1000,
  parameter int RAMP_STEP    = 50,
  parameter int FWD_SPEED    = 700,
  parameter int TURN_SPEED   = 550,
  parameter int SEARCH_SPEED = 450,
  parameter int LOST_CYC     = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] sensor,
  input  logic       obstacle,
  output logic [1:0] mode,
  output logic [9:0] speed,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_LEFT  = 3'd2,
    S_RIGHT = 3'd3,
    S_LOST  = 3'd4,
    S_BLOCK = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int FCW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam int DCW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int LCW = (LOST_CYC > 1) ? $clog2(LOST_CYC) : 1;

  // ---------------------------------------------------------------------
  // Sensor filter: a raw pattern must sit unchanged for FILT_CYC cycles
  // before it is copied to filt. The count saturates at FILT_CYC-1 and
  // keeps reloading filt with the same value while the input is stable.
  // ---------------------------------------------------------------------
  logic [2:0]     filt, cand;
  logic [FCW-1:0] filt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt     <= 3'b010;
      cand     <= 3'b010;
      filt_cnt <= '0;
    end else if (sensor != cand) begin
      cand     <= sensor;
      filt_cnt <= '0;
    end else if (filt_cnt == FCW'(FILT_CYC - 1)) begin
      filt     <= cand;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Tracking FSM
  // ---------------------------------------------------------------------
  state_t         state, nxt, mapped;
  dir_t           last_dir;
  logic [LCW-1:0] lost_cnt;
  logic           lost_to;

  // 101 is ambiguous (line under both outer sensors): hold the current
  // heading, except from the stopped states where we just go straight.
  function automatic state_t sensor_state(input logic [2:0] s, input state_t cur);
    state_t r;
    case (s)
      3'b010, 3'b111: r = S_FWD;
      3'b110, 3'b100: r = S_LEFT;
      3'b011, 3'b001: r = S_RIGHT;
      3'b000:         r = S_LOST;
      default:        r = (cur == S_IDLE || cur == S_BLOCK) ? S_FWD : cur;
    endcase
    sensor_state = r;
  endfunction

  assign mapped  = sensor_state(filt, state);
  assign lost_to = (state == S_LOST) && (lost_cnt == LCW'(LOST_CYC - 1));

  // Priority: !enable > obstacle > lost timeout > filtered sensor.
  always_comb begin
    nxt = state;
    if (!enable) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:                 nxt = mapped;
        S_FWD, S_LEFT, S_RIGHT: nxt = obstacle ? S_BLOCK : mapped;
        S_LOST: begin
          if (obstacle)     nxt = S_BLOCK;
          else if (lost_to) nxt = S_HALT;
          else              nxt = mapped;
        end
        S_BLOCK:                nxt = obstacle ? S_BLOCK : mapped;
        S_HALT:                 nxt = S_HALT;
        default:                nxt = S_IDLE;
      endcase
    end
  end

  // State, search bookkeeping and the mode decode. mode is decoded from the
  // registered state, so it trails a state change by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      last_dir <= DIR_LEFT;
      lost_cnt <= '0;
      mode     <= 2'b00;
    end else begin
      state <= nxt;
      if (nxt == S_LEFT)       last_dir <= DIR_LEFT;
      else if (nxt == S_RIGHT) last_dir <= DIR_RIGHT;
      // Zero whenever outside LOST, so every LOST entry starts from 0.
      lost_cnt <= (state == S_LOST) ? lost_cnt + 1'b1 : '0;
      case (state)
        S_FWD:   mode <= 2'b01;
        S_LEFT:  mode <= 2'b10;
        S_RIGHT: mode <= 2'b11;
        // Spin toward the side the line was last seen on.
        S_LOST:  mode <= (last_dir == DIR_LEFT) ? 2'b10 : 2'b11;
        default: mode <= 2'b00;
      endcase
    end
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // Speed ramp
  // ---------------------------------------------------------------------
  logic [9:0]     target;
  logic [DCW-1:0] div;
  logic           tick;
  logic [10:0]    sum;

  always_comb begin
    target = '0;
    case (state)
      S_FWD:          target = 10'(FWD_SPEED);
      S_LEFT, S_RIGHT: target = 10'(TURN_SPEED);
      S_LOST:         target = 10'(SEARCH_SPEED);
      default:        target = '0;
    endcase
  end

  assign tick = (div == DCW'(RAMP_DIV - 1));
  // One spare bit so speed + step cannot wrap past 1023 before the clamp.
  assign sum  = {1'b0, speed} + 11'(RAMP_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      div   <= '0;
      speed <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      // Slowing down is immediate; only acceleration is rate limited.
      if (target < speed)
        speed <= target;
      else if (tick)
        speed <= (sum > {1'b0, target}) ? target : sum[9:0];
    end
  end

endmodule

// File: tb/tb_line_drive_ctrl.sv
// Directed bench for line_drive_ctrl with small parameters so every timing
// point can be worked out by hand. Edge numbers count rising edges after
// the last reset edge; ramp ticks land on edges that are multiples of 4
// (until the mid-ramp reset, after which they land on 177+4k).
module tb_line_drive_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, obstacle;
  logic [2:0] sensor;
  logic [1:0] mode;
  logic [9:0] speed;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  // State encodings seen on state_dbg
  localparam int IDLE = 0, FWD = 1, LEFT = 2, RIGHT = 3, LOST = 4, BLOCK = 5, HALT = 6;

  line_drive_ctrl #(
    .FILT_CYC(4), .RAMP_DIV(4), .RAMP_STEP(100), .FWD_SPEED(700),
    .TURN_SPEED(550), .SEARCH_SPEED(450), .LOST_CYC(64)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensor(sensor), .obstacle(obstacle),
    .mode(mode), .speed(speed), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // e: edge to stop after; m/sp/st: expected outputs (-1 = not checked);
  // en/sen/obs: inputs driven after the check (-1 = unchanged).
  typedef struct {
    int e; int m; int sp; int st; int en; int sen; int obs;
  } vec_t;

  vec_t tab1 [19];
  vec_t tab2 [13];

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int n);
    if (e > n) begin
      checks++;
      failures++;
      $display("FAIL schedule: at edge %0d, required edge %0d already passed", e, n);
    end
    while (e < n) tick();
  endtask

  task automatic chk(input string nm, input int m, input int sp, input int st);
    if (m >= 0) begin
      checks++;
      if (int'(mode) != m) begin
        failures++;
        $display("FAIL %s mode @edge %0d: got %0d want %0d", nm, e, mode, m);
      end
    end
    if (sp >= 0) begin
      checks++;
      if (int'(speed) != sp) begin
        failures++;
        $display("FAIL %s speed @edge %0d: got %0d want %0d", nm, e, speed, sp);
      end
    end
    if (st >= 0) begin
      checks++;
      if (int'(state_dbg) != st) begin
        failures++;
        $display("FAIL %s state @edge %0d: got %0d want %0d", nm, e, state_dbg, st);
      end
    end
  endtask

  task automatic apply_vec(input string nm, input vec_t v);
    run_to(v.e);
    chk(nm, v.m, v.sp, v.st);
    if (v.en  >= 0) enable   = v.en[0];
    if (v.sen >= 0) sensor   = v.sen[2:0];
    if (v.obs >= 0) obstacle = v.obs[0];
  endtask

  initial begin
    // Start-up ramp, glitch rejection, and the turn into LEFT.
    tab1 = '{
      '{ 1, 0,   0, FWD,  -1, -1, -1},
      '{ 2, 1,   0, FWD,  -1, -1, -1},
      '{ 3, 1,   0, -1,   -1, -1, -1},
      '{ 4, -1, 100, -1,  -1, -1, -1},
      '{ 7, -1, 100, -1,  -1, -1, -1},
      '{ 8, -1, 200, -1,  -1, -1, -1},
      '{12, -1, 300, -1,  -1, -1, -1},
      '{16, -1, 400, -1,  -1, -1, -1},
      '{20, -1, 500, -1,  -1, -1, -1},
      '{24, -1, 600, -1,  -1, -1, -1},
      '{27, -1, 600, -1,  -1, -1, -1},
      '{28, 1,  700, FWD, -1, -1, -1},
      '{36, 1,  700, FWD, -1,  6, -1},   // 2-cycle 110 glitch
      '{38, 1,  700, FWD, -1,  2, -1},
      '{44, 1,  700, FWD, -1,  6, -1},   // real 110, held 10 cycles
      '{49, 1,  700, FWD, -1, -1, -1},   // filtered updates on this edge
      '{50, 1,  700, LEFT, -1, -1, -1},
      '{51, 2,  550, LEFT, -1, -1, -1},
      '{54, 2,  550, LEFT, -1,  0, -1}
    };
    // RIGHT, ambiguous 101, 111, LOST toward the right, obstacle in LOST.
    tab2 = '{
      '{184, -1, -1, FWD,   -1, -1, -1},
      '{188, -1, -1, FWD,   -1, -1, -1},
      '{189,  1, -1, RIGHT, -1, -1, -1},
      '{190,  3, -1, RIGHT, -1,  5, -1},
      '{200,  3, -1, RIGHT, -1,  7, -1},
      '{205, -1, -1, RIGHT, -1, -1, -1},
      '{206,  3, -1, FWD,   -1, -1, -1},
      '{207,  1, -1, FWD,   -1,  0, -1},
      '{212, -1, -1, FWD,   -1, -1, -1},
      '{213, -1, -1, LOST,  -1, -1, -1},
      '{214,  3, -1, LOST,  -1, -1,  1},
      '{215, -1, -1, BLOCK, -1, -1, -1},
      '{216,  0,  0, BLOCK, -1, -1, -1}
    };

    rst = 1'b1; enable = 1'b0; sensor = 3'b010; obstacle = 1'b0;
    tick(); tick();
    e = 0;
    chk("reset", 0, 0, IDLE);
    rst = 1'b0; enable = 1'b1;

    for (int i = 0; i < 19; i++) apply_vec("ramp_turn", tab1[i]);

    // LEFT -> LOST (spins left) -> HALT after 64 cycles in LOST
    run_to(59);  chk("lost_filt",  2, 550, LEFT);
    run_to(60);  chk("lost_enter", 2, 550, LOST);
    run_to(61);  chk("lost_mode",  2, 450, LOST);
    run_to(123); chk("lost_last",  2, 450, LOST);
    run_to(124); chk("halt_enter", 2, -1, HALT);
    run_to(125); chk("halt_out",   0, 0, HALT);
    sensor = 3'b010; obstacle = 1'b1;           // both ignored in HALT
    run_to(135); chk("halt_hold",  0, 0, HALT);
    obstacle = 1'b0; enable = 1'b0;
    run_to(136); chk("halt_exit", -1, -1, IDLE);
    enable = 1'b1;

    // Fresh ramp, then obstacle pulse into BLOCK and recovery
    run_to(137); chk("fwd_again", -1, -1, FWD);
    run_to(138); chk("fwd_mode",   1, 0, FWD);
    run_to(140); chk("ramp2_1",   -1, 100, -1);
    run_to(163); chk("ramp2_6",   -1, 600, -1);
    run_to(164); chk("ramp2_top",  1, 700, FWD);
    obstacle = 1'b1;
    run_to(165); chk("block",      1, 700, BLOCK);
    obstacle = 1'b0;
    run_to(166); chk("block_out",  0, 0, FWD);
    run_to(167); chk("resume",     1, 0, FWD);
    run_to(168); chk("resume_1",  -1, 100, -1);
    run_to(176); chk("resume_3",  -1, 300, FWD);

    // Reset mid-ramp, then enable drop
    rst = 1'b1;
    run_to(177); chk("mid_rst",    0, 0, IDLE);
    rst = 1'b0;
    run_to(178); chk("post_rst",   0, 0, FWD);
    run_to(179); chk("post_rst_m", 1, 0, FWD);
    run_to(180); chk("post_rst_s", -1, 0, -1);
    run_to(181); chk("post_rst_t", 1, 100, FWD);
    enable = 1'b0;
    run_to(182); chk("disable",   -1, -1, IDLE);
    run_to(183); chk("disable_o",  0, 0, IDLE);
    enable = 1'b1; sensor = 3'b011;

    for (int i = 0; i < 13; i++) apply_vec("right_lost", tab2[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the schedule above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units at edge %0d", e);
    $fatal(1);
  end

endmodule
